// File: rtl/uart_reg_pkg.sv
// Shared definitions for the 3-byte UART register protocol: field widths,
// command codes, reply byte order and the initiator state encoding.
package uart_reg_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    localparam logic [1:0] CMD_READ  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;

    // Reply bytes arrive in this order after a read frame.
    localparam int REPLY_ECHO  = 0;
    localparam int REPLY_HI    = 1;
    localparam int REPLY_LO    = 2;
    localparam int REPLY_BYTES = 3;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SEND_CMD = 4'd1,
        WAIT_CMD = 4'd2,
        SEND_HI  = 4'd3,
        WAIT_HI  = 4'd4,
        SEND_LO  = 4'd5,
        WAIT_LO  = 4'd6,
        RX_ECHO  = 4'd7,
        RX_HI    = 4'd8,
        RX_LO    = 4'd9,
        RESP     = 4'd10
    } state_t;

    function automatic logic [7:0] cmd_byte(input logic write, input logic [ADDR_W-1:0] addr);
        return {(write ? CMD_WRITE : CMD_READ), addr};
    endfunction

endpackage

// File: rtl/uart_rx.sv
// Byte receiver: 8N1, mid-bit sampling. RXNE stays set with the byte held on
// Rx_D until RD is pulsed; a byte with a bad stop bit is dropped.
module UART_Rx #(
    parameter int CLOCK     = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Rx,
    input  logic       RD,
    output logic [7:0] Rx_D,
    output logic       RXNE
);
    localparam int DIV = CLOCK / BAUD_RATE;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

    logic          rx_s1, rx_s2, busy;
    logic [3:0]    nbit;
    logic [CW-1:0] bcnt;
    logic [7:0]    shreg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            busy  <= 1'b0;
            nbit  <= '0;
            bcnt  <= '0;
            shreg <= '0;
            Rx_D  <= '0;
            RXNE  <= 1'b0;
        end else begin
            rx_s1 <= Rx;
            rx_s2 <= rx_s1;
            if (RD) RXNE <= 1'b0;
            if (!busy) begin
                bcnt <= '0;
                nbit <= '0;
                if (!rx_s2) busy <= 1'b1;
            end else if (bcnt == ((nbit == 4'd0) ? HALF : FULL)) begin
                bcnt <= '0;
                // nbit 0 re-checks the start bit at its midpoint to reject glitches.
                if (nbit == 4'd0) begin
                    if (rx_s2) busy <= 1'b0;
                    else       nbit <= 4'd1;
                end else if (nbit <= 4'd8) begin
                    shreg <= {rx_s2, shreg[7:1]};
                    nbit  <= nbit + 4'd1;
                end else begin
                    busy <= 1'b0;
                    if (rx_s2) begin
                        Rx_D <= shreg;
                        RXNE <= 1'b1;
                    end
                end
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Byte transmitter: 8N1 framing, LSB first. TXE is high while idle and rises
// again once the stop bit of the current byte has been fully sent.
module UART_Tx #(
    parameter int CLOCK     = 100_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       WR,
    input  logic [7:0] Tx_D,
    output logic       Tx,
    output logic       TXE
);
    localparam int DIV = CLOCK / BAUD_RATE;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);

    logic [9:0]    shreg;
    logic [3:0]    nbit;
    logic [CW-1:0] bcnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Tx    <= 1'b1;
            TXE   <= 1'b1;
            shreg <= '1;
            nbit  <= '0;
            bcnt  <= '0;
        end else if (TXE) begin
            if (WR) begin
                shreg <= {1'b1, Tx_D, 1'b0};
                Tx    <= 1'b0;
                TXE   <= 1'b0;
                nbit  <= '0;
                bcnt  <= '0;
            end
        end else if (bcnt == FULL) begin
            bcnt <= '0;
            // nbit counts completed bit periods: start, 8 data, stop.
            if (nbit == 4'd9) begin
                TXE <= 1'b1;
                Tx  <= 1'b1;
            end else begin
                nbit  <= nbit + 4'd1;
                shreg <= {1'b1, shreg[9:1]};
                Tx    <= shreg[1];
            end
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_reg_master.sv
// Host-side initiator: turns a register read/write request into a
// {cmd, hi, lo} UART frame and, for reads, collects the {echo, hi, lo} reply.
module uart_reg_master
    import uart_reg_pkg::*;
#(
    parameter int CLOCK          = 100_000_000,
    parameter int BAUD_RATE      = 115200,
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              UartRx,
    output logic              UartTx,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              rsp_err
);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Request: transfer on the rising clock where req_valid && req_ready; the
    // requester holds its fields until then. rsp_valid is a one-cycle pulse with
    // rsp_timeout/rsp_err qualifying it; there is no back-pressure on responses.

    state_t            state;
    logic              wr, rd, txe, rxne, prev_txe, prev_rxne, err;
    logic [7:0]        tx_d, rx_d, cmd;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [TW-1:0]     tcnt;
    logic [7:0]        reply [REPLY_BYTES];
    logic              txe_rise, rxne_rise;

    assign txe_rise  = txe & ~prev_txe;
    assign rxne_rise = rxne & ~prev_rxne;

    UART_Tx #(.CLOCK(CLOCK), .BAUD_RATE(BAUD_RATE)) u_tx (
        .CLK (CLK),
        .RST (RST),
        .WR  (wr),
        .Tx_D(tx_d),
        .Tx  (UartTx),
        .TXE (txe)
    );

    UART_Rx #(.CLOCK(CLOCK), .BAUD_RATE(BAUD_RATE)) u_rx (
        .CLK (CLK),
        .RST (RST),
        .Rx  (UartRx),
        .RD  (rd),
        .Rx_D(rx_d),
        .RXNE(rxne)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
            rsp_err     <= 1'b0;
            wr          <= 1'b0;
            rd          <= 1'b0;
            tx_d        <= '0;
            cmd         <= '0;
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            prev_txe    <= 1'b1;
            prev_rxne   <= 1'b0;
            err         <= 1'b0;
            tcnt        <= '0;
            reply       <= '{default: '0};
        end else begin
            prev_txe  <= txe;
            prev_rxne <= rxne;
            wr        <= 1'b0;
            // Every received byte is read out regardless of state, so strays
            // never leave RXNE stuck; only the RX_* states keep the data.
            rd        <= rxne_rise;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cmd       <= cmd_byte(req_write, req_addr);
                        err       <= 1'b0;
                        req_ready <= 1'b0;
                        state     <= SEND_CMD;
                    end
                end
                SEND_CMD: if (txe) begin tx_d <= cmd;              wr <= 1'b1; state <= WAIT_CMD; end
                WAIT_CMD: if (txe_rise) state <= SEND_HI;
                SEND_HI:  if (txe) begin tx_d <= lat_wdata[15:8];  wr <= 1'b1; state <= WAIT_HI;  end
                WAIT_HI:  if (txe_rise) state <= SEND_LO;
                SEND_LO:  if (txe) begin tx_d <= lat_wdata[7:0];   wr <= 1'b1; state <= WAIT_LO;  end
                WAIT_LO: begin
                    if (txe_rise) begin
                        if (lat_write) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            tcnt  <= '0;
                            state <= RX_ECHO;
                        end
                    end
                end
                RX_ECHO: begin
                    if (rd) begin
                        reply[REPLY_ECHO] <= rx_d;
                        if (rx_d != {CMD_READ, lat_addr}) err <= 1'b1;
                        tcnt  <= '0;
                        state <= RX_HI;
                    end else if (tcnt == T_LAST) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RX_HI: begin
                    if (rd) begin
                        reply[REPLY_HI] <= rx_d;
                        tcnt  <= '0;
                        state <= RX_LO;
                    end else if (tcnt == T_LAST) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RX_LO: begin
                    if (rd) begin
                        reply[REPLY_LO] <= rx_d;
                        tcnt      <= '0;
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        rsp_rdata <= err ? '0 : {reply[REPLY_HI], rx_d};
                    end else if (tcnt == T_LAST) begin
                        state       <= RESP;
                        rsp_valid   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid   <= 1'b0;
                    rsp_timeout <= 1'b0;
                    rsp_err     <= 1'b0;
                    req_ready   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_reg_master.md
Name: uart_reg_master

Overview:
- Host-side initiator for the team's 3-byte UART register protocol: turns a parallel register read/write request into a serial command frame and, for reads, collects the 3-byte reply.
- Lets an FPGA-side controller (or a loopback test top) drive the UART register-memory slave over a single UART link.
- Instantiates the existing UART_Rx and UART_Tx byte modules internally.

Parameters:
- CLOCK, 100_000_000, clock frequency in Hz; passed to UART_Rx/UART_Tx.
- BAUD_RATE, 115200, line rate; passed to UART_Rx/UART_Tx.
- TIMEOUT_CYCLES, 100_000, maximum cycles allowed waiting for any single reply byte.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset; also drives the UART_Rx/UART_Tx RST inputs.
- UartRx  in  1  serial input from the slave's TX.
- UartTx  out  1  serial output to the slave's RX.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; a request is accepted on the cycle where req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  6  register address.
- req_wdata  in  16  write data (ignored for reads).
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read data; 0 for writes, timeouts and errors.
- rsp_timeout  out  1  qualifies rsp_valid: a reply byte timed out.
- rsp_err  out  1  qualifies rsp_valid: the echo byte did not equal {2'b00, addr}.

Behaviour:
- Reset values:
  - req_ready = 1; rsp_valid, rsp_timeout and rsp_err = 0; rsp_rdata = 0.
  - UartTx idles high (driven by UART_Tx); internal WR/RD = 0; state = IDLE.
- Accept:
  - On req_valid && req_ready, latch write, addr and wdata.
  - Form the command byte: {2'b01, addr} for a write, {2'b00, addr} for a read.
  - Drop req_ready the next cycle.
- Frame sent, in order: command, wdata[15:8], wdata[7:0]. Reads send wdata as the latched value, which the slave ignores.
- Tx handshake:
  - In each SEND state, wait until TXE = 1, then drive Tx_D and pulse WR for exactly one cycle.
  - Move to that byte's WAIT state.
  - Leave the WAIT state on the TXE rising edge (registered prevTXE = 0, TXE = 1).
- States: IDLE, SEND_CMD, WAIT_CMD, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, RX_ECHO, RX_HI, RX_LO, RESP.
- Write path:
  - WAIT_LO goes to RESP on the TXE rising edge.
  - rsp_valid = 1 with rdata = 0 and both flags 0.
- Read path:
  - WAIT_LO goes to RX_ECHO.
  - Expected reply bytes, in order: echo {2'b00, addr}, data[15:8], data[7:0].
- Rx handshake:
  - On the RXNE rising edge, pulse RD for one cycle.
  - Capture Rx_D on the following cycle, which is the cycle RD is high.
- Reply capture:
  - RX_ECHO: compare the echo byte; a mismatch sets a sticky err bit, but reception continues.
  - RX_HI: capture the high byte.
  - RX_LO: capture the low byte, then go to RESP with rdata = {hi, lo}. If err is set, rdata = 0 and rsp_err = 1.
- Timeout:
  - A counter clears on entry to each RX_* state and on every captured byte.
  - When it reaches TIMEOUT_CYCLES - 1: go to RESP with rsp_timeout = 1, rdata = 0.
  - Any bytes still in flight are later discarded as strays.
- RESP:
  - rsp_* are valid for exactly one cycle.
  - Next cycle: state returns to IDLE, req_ready = 1, rsp_valid = 0 (rsp_rdata holds its value).
- Stray bytes: Rx bytes arriving in IDLE or in any SEND/WAIT state are read (RD pulsed) and discarded, so RXNE never stays set.
- Simultaneous events: an RXNE edge arriving while a WR pulse is issued is serviced independently; the Rx and Tx handshakes never block each other.
- req_valid while busy: ignored (no queue); the requester holds the request until req_ready.
- Reset mid-operation: immediate return to reset values; a partly sent frame is abandoned, and resynchronising the slave is the system's responsibility.

Decomposition:
- Shared package (uart_reg_pkg):
  - CMD_READ = 2'b00, CMD_WRITE = 2'b01.
  - ADDR_W = 6, DATA_W = 16.
  - Reply order constants.
  - State encoding localparams.
- Reuse the existing UART_Rx and UART_Tx modules; no new sub-module.
- The FSM, timeout counter and edge detectors stay in uart_reg_master.

Test Plan:
- Loopback against the UART register-memory slave: write addr 3 = 16'hBEEF, then read addr 3 -> first rsp_valid has rdata = 0; second has rdata = 16'hBEEF; both with rsp_err = 0 and rsp_timeout = 0.
- Write-frame check: serial monitor on UartTx during write addr 5 = 16'h1234 -> bytes 8'h45, 8'h12, 8'h34; rsp_valid exactly one cycle after the last byte's TXE rise.
- Read with no slave (UartRx held high), TIMEOUT_CYCLES = 1000 -> rsp_timeout = 1, rdata = 0 within about 1000 cycles of the end of the frame; req_ready back to 1.
- Bench slave replies to addr 2 with 8'h07, 8'hAA, 8'h55 -> rsp_err = 1, rdata = 0.
- Stray byte 8'h99 injected on UartRx while idle -> RD pulses once; no rsp_valid; a following read of addr 0 returns the correct data.
- Assert RST during SEND_HI -> req_ready = 1 and UartTx idle high after reset; the next write after a slave reset completes normally.
